rv32i_dport_arbiter: RTL and testbench
======================================

// Module: rv32i_dport_arbiter
// PURPOSE
//  Shares the single data port of the sync dual-port RAM between the pipeline memory stage (CPU)
//  and a program loader/debug master (LDR). CPU has priority; a starvation counter guarantees
//  LDR forward progress; LDR may hold the port for a bounded burst. Sits between the memory stage
//  and the RAM d-port. Raises cpu_stall so the pipeline freezes while it is denied.
// PARAMETERS
//  ADDR_W      30  word-address width (byte address bits [31:2])
//  DATA_W      32  data width
//  STARVE_MAX  8   consecutive denied LDR cycles before LDR overrides CPU (>=1)
//  BURST_MAX   16  max LDR beats per ownership before forced release (>=1)
// PORTS
//  clk         in   1       clock
//  reset       in   1       reset: asynchronous, active-low (0 = in reset)
//  cpu_req     in   1       CPU access request (valid with cpu_we/be/addr/wdata)
//  cpu_we      in   1       CPU write (0 = read)
//  cpu_be      in   4       CPU byte enables
//  cpu_addr    in   ADDR_W  CPU word address
//  cpu_wdata   in   DATA_W  CPU write data
//  cpu_gnt     out  1       CPU beat accepted this cycle
//  cpu_stall   out  1       cpu_req & !cpu_gnt
//  cpu_rvalid  out  1       CPU read data valid (1 cycle after read grant)
//  cpu_rdata   out  DATA_W  CPU read data
//  ldr_req/ldr_we/ldr_be/ldr_addr/ldr_wdata  in  1/1/4/ADDR_W/DATA_W  LDR request, as CPU
//  ldr_last    in   1       current LDR beat ends its burst
//  ldr_gnt     out  1       LDR beat accepted this cycle
//  ldr_rvalid  out  1       LDR read data valid
//  ldr_rdata   out  DATA_W  LDR read data
//  d_we/d_be/d_addr/d_wdata  out  1/4/ADDR_W/DATA_W  to RAM data port
//  d_rdata     in   DATA_W  from RAM (registered, 1-cycle read latency)
// BEHAVIOUR
//  - Grants combinational from state + requests; granted master's fields muxed to d_* same cycle.
//    No grant: d_we=0, d_be=0, d_addr=0, d_wdata=0. d_we only on granted write beat.
//  - FSM (2 states, reset -> S_CPU):
//    S_CPU: starve_cnt==STARVE_MAX & ldr_req -> ldr_gnt; else cpu_req -> cpu_gnt;
//      else ldr_req -> ldr_gnt. Any ldr_gnt with !ldr_last -> S_LDR, beat_cnt=1.
//    S_LDR: cpu_gnt=0; ldr_gnt=ldr_req; beat_cnt++ per ldr_gnt. -> S_CPU when: granted beat has
//      ldr_last, OR beat_cnt reaches BURST_MAX on a granted beat, OR ldr_req=0 (burst abandoned).
//      Both ldr_last and BURST_MAX on one beat -> single release, no extra cycle.
//  - starve_cnt: +1 each cycle ldr_req & !ldr_gnt, saturates at STARVE_MAX; cleared on ldr_gnt.
//  - Read return: owner tag + read flag registered on grant; next cycle rvalid=1 for that owner
//    only, rdata=d_rdata; other master rdata=0. Back-to-back reads: one rvalid per read grant.
//  - Writes produce no rvalid. Never both gnts in one cycle.
//  - Reset (async, any time incl. mid-burst): state=S_CPU, starve_cnt=0, beat_cnt=0, both
//    rvalid=0, both rdata=0; while reset=0 both gnt=0, cpu_stall=0, d_we=0, d_be=0, d_addr=0,
//    d_wdata=0. In-flight read return discarded.
//  - Counter widths $clog2(MAX+1); no wrap permitted.
// STRUCTURE
//  - rv32i_pkg: arb_state_t {S_CPU,S_LDR}; owner_t {OWN_NONE,OWN_CPU,OWN_LDR}.
//  - Sub-module rv32i_sat_counter (inc, clr, sat value param) for starve_cnt and beat_cnt.
//  - Rest inline: FSM, grant logic, d-port mux, read-return register.
// TESTING
//  1 CPU only: read addr 0x10 (RAM=0xDEADBEEF) -> cpu_gnt same cycle, cpu_rvalid+0xDEADBEEF next, no stall.
//  2 Contention, STARVE_MAX=8: both req constant -> CPU granted 8 cycles, cycle 9 ldr_gnt,
//    cpu_stall=1 that cycle, starve_cnt back to 0.
//  3 LDR burst of 4 writes, ldr_last on beat 4, cpu_req high -> 4 ldr_gnts, cpu_stall=1 for 4
//    cycles, cpu_gnt on cycle 5.
//  4 BURST_MAX=16, LDR 20-beat no ldr_last -> release after beat 16, CPU beat, LDR resumes.
//  5 Reset=0 mid-burst beat 3 with read pending -> rvalid=0, gnts=0, d_we=0; after release S_CPU.
//  6 Alternating CPU read/LDR read -> each rvalid to correct owner only, data matches address.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared types for the data-port arbiter
package rv32i_pkg;

    typedef enum logic {S_CPU, S_LDR} arb_state_t;

    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_LDR} owner_t;

endpackage

// File: rtl/rv32i_sat_counter.sv
// rv32i_sat_counter: up-counter that sticks at MAX, clear wins over increment
module rv32i_sat_counter #(
    parameter int MAX = 8,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // count up to MAX and hold there until cleared
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && cnt != W'(MAX))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/rv32i_dport_arbiter.sv
// rv32i_dport_arbiter: shares the RAM data port between the CPU memory stage and the loader
module rv32i_dport_arbiter
    import rv32i_pkg::*;
#(
    parameter int ADDR_W     = 30,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8,
    parameter int BURST_MAX  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [3:0]        cpu_be,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [3:0]        ldr_be,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    input  logic              ldr_last,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              d_we,
    output logic [3:0]        d_be,
    output logic [ADDR_W-1:0] d_addr,
    output logic [DATA_W-1:0] d_wdata,
    input  logic [DATA_W-1:0] d_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int BW = $clog2(BURST_MAX + 1);

    arb_state_t    state, state_nx;
    owner_t        rd_own;
    logic [SW-1:0] starve_cnt;
    logic [BW-1:0] beat_cnt;

    rv32i_sat_counter #(.MAX(STARVE_MAX)) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (ldr_req && !ldr_gnt),
        .clr   (ldr_gnt),
        .cnt   (starve_cnt)
    );

    // beat_cnt holds the number of beats already granted in the current LDR ownership
    rv32i_sat_counter #(.MAX(BURST_MAX)) u_beat (
        .clk   (clk),
        .reset (reset),
        .inc   (ldr_gnt),
        .clr   (state_nx == S_CPU),
        .cnt   (beat_cnt)
    );

    // grant decision and next state; nothing is granted while reset is held
    always_comb begin
        cpu_gnt  = 1'b0;
        ldr_gnt  = 1'b0;
        state_nx = state;
        if (reset) begin
            if (state == S_CPU) begin
                if (ldr_req && starve_cnt == SW'(STARVE_MAX))
                    ldr_gnt = 1'b1;
                else if (cpu_req)
                    cpu_gnt = 1'b1;
                else
                    ldr_gnt = ldr_req;
                if (ldr_gnt && !ldr_last && BURST_MAX > 1)
                    state_nx = S_LDR;
            end else begin
                ldr_gnt = ldr_req;
                if (!ldr_req || ldr_last || beat_cnt == BW'(BURST_MAX - 1))
                    state_nx = S_CPU;
            end
        end
    end

    assign cpu_stall = reset && cpu_req && !cpu_gnt;
    assign d_we      = cpu_gnt ? cpu_we    : ldr_gnt ? ldr_we    : 1'b0;
    assign d_be      = cpu_gnt ? cpu_be    : ldr_gnt ? ldr_be    : 4'd0;
    assign d_addr    = cpu_gnt ? cpu_addr  : ldr_gnt ? ldr_addr  : '0;
    assign d_wdata   = cpu_gnt ? cpu_wdata : ldr_gnt ? ldr_wdata : '0;

    // arbitration state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_CPU;
        else
            state <= state_nx;
    end

    // remember who issued a read so the RAM's registered data goes back to that master only
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rd_own <= OWN_NONE;
        else
            rd_own <= (cpu_gnt && !cpu_we) ? OWN_CPU : (ldr_gnt && !ldr_we) ? OWN_LDR : OWN_NONE;
    end

    assign cpu_rvalid = rd_own == OWN_CPU;
    assign ldr_rvalid = rd_own == OWN_LDR;
    assign cpu_rdata  = cpu_rvalid ? d_rdata : '0;
    assign ldr_rdata  = ldr_rvalid ? d_rdata : '0;

endmodule

// File: tb/tb_rv32i_dport_arbiter.sv
// tb_rv32i_dport_arbiter: directed stimulus with a scoreboard monitor for the data-port arbiter
module tb_rv32i_dport_arbiter;

    typedef struct packed {
        logic        cg;
        logic        lg;
        logic        st;
        logic        we;
        logic [3:0]  be;
        logic [29:0] addr;
        logic [31:0] wd;
    } cyc_t;

    typedef struct packed {
        logic        ldr;
        logic [31:0] data;
    } rd_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rst_val = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, ldr_req = 1'b0, ldr_we = 1'b0, ldr_last = 1'b0;
    logic [3:0]  cpu_be = 4'd0, ldr_be = 4'd0;
    logic [29:0] cpu_addr = '0, ldr_addr = '0;
    logic [31:0] cpu_wdata = '0, ldr_wdata = '0;
    logic        cpu_gnt, cpu_stall, cpu_rvalid, ldr_gnt, ldr_rvalid, d_we;
    logic [31:0] cpu_rdata, ldr_rdata, d_wdata;
    logic [31:0] d_rdata = '0;
    logic [3:0]  d_be;
    logic [29:0] d_addr;

    cyc_t exp_q[$];
    rd_t  rd_q[$];
    cyc_t e;
    rd_t  r;
    int   checks = 0;
    int   errors = 0;

    rv32i_dport_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_be     (cpu_be),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ldr_req    (ldr_req),
        .ldr_we     (ldr_we),
        .ldr_be     (ldr_be),
        .ldr_addr   (ldr_addr),
        .ldr_wdata  (ldr_wdata),
        .ldr_last   (ldr_last),
        .ldr_gnt    (ldr_gnt),
        .ldr_rvalid (ldr_rvalid),
        .ldr_rdata  (ldr_rdata),
        .d_we       (d_we),
        .d_be       (d_be),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata)
    );

    always #5 clk = ~clk;

    // RAM stand-in: registered read, word 16 holds DEADBEEF, every other word is A5A5_<addr>
    always @(posedge clk)
        d_rdata <= (d_addr == 30'd16) ? 32'hDEADBEEF : {16'hA5A5, d_addr[15:0]};

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // one cycle of stimulus; ecg/elg are the hand-computed grants, rdx the data a read must return
    task automatic step(input logic cr, cw, input logic [29:0] ca, input logic lr, lw,
                        input logic [29:0] la, input logic ll, input logic ecg, elg,
                        input logic [31:0] rdx);
        cyc_t x;
        @(posedge clk);
        #1;
        reset     = rst_val;
        cpu_req   = cr;
        cpu_we    = cw;
        cpu_addr  = ca;
        cpu_be    = 4'hF;
        cpu_wdata = {2'b0, ca} ^ 32'hC0DE0000;
        ldr_req   = lr;
        ldr_we    = lw;
        ldr_addr  = la;
        ldr_be    = 4'hC;
        ldr_wdata = {2'b0, la} ^ 32'h1D000000;
        ldr_last  = ll;
        x.cg   = ecg;
        x.lg   = elg;
        x.st   = cr && !ecg && rst_val;
        x.we   = ecg ? cw : elg ? lw : 1'b0;
        x.be   = ecg ? 4'hF : elg ? 4'hC : 4'h0;
        x.addr = ecg ? ca : elg ? la : 30'd0;
        x.wd   = ecg ? ({2'b0, ca} ^ 32'hC0DE0000) : elg ? ({2'b0, la} ^ 32'h1D000000) : 32'd0;
        exp_q.push_back(x);
        if (ecg && !cw) rd_q.push_back('{1'b0, rdx});
        if (elg && !lw) rd_q.push_back('{1'b1, rdx});
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // monitor: compares the cycle record and any read return against the queues
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("gnt_stall", {cpu_gnt, ldr_gnt, cpu_stall}, {e.cg, e.lg, e.st});
            chk("dport", {d_we, d_be, d_addr, d_wdata}, {e.we, e.be, e.addr, e.wd});
        end
        if (cpu_rvalid || ldr_rvalid) begin
            if (rd_q.size() == 0)
                chk("spurious_rvalid", {cpu_rvalid, ldr_rvalid}, 0);
            else begin
                r = rd_q.pop_front();
                chk("rvalid_owner", {cpu_rvalid, ldr_rvalid}, r.ldr ? 2'b01 : 2'b10);
                chk("rdata", r.ldr ? ldr_rdata : cpu_rdata, r.data);
                chk("other_rdata", r.ldr ? cpu_rdata : ldr_rdata, 0);
            end
        end else
            chk("idle_rdata", {cpu_rdata, ldr_rdata}, 0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset held with both masters requesting: nothing may reach the port
        repeat (2) step(1, 1, 16, 1, 1, 40, 1, 0, 0, 0);
        rst_val = 1'b1;
        // CPU-only read
        step(1, 0, 16, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF);
        idle();
        // constant contention: 8 CPU grants then one LDR grant, twice (starve count restarts)
        repeat (2)
            for (int i = 0; i < 9; i++) step(1, 1, 32, 1, 1, 40, 1, i < 8, i == 8, 0);
        idle();
        // starvation-won LDR burst of 4 writes with CPU waiting throughout
        for (int i = 0; i < 8; i++) step(1, 1, 33, 1, 1, 40, 0, 1, 0, 0);
        step(1, 1, 33, 1, 1, 40, 0, 0, 1, 0);
        step(1, 1, 33, 1, 1, 41, 0, 0, 1, 0);
        step(1, 1, 33, 1, 1, 42, 0, 0, 1, 0);
        step(1, 1, 33, 1, 1, 43, 1, 0, 1, 0);
        step(1, 1, 33, 0, 0, 0, 0, 1, 0, 0);
        idle();
        // 20-beat LDR write burst without ldr_last: forced release after beat 16
        for (int k = 0; k < 16; k++) step(k >= 14, 0, 2, 1, 1, 30'(44 + k), 0, 0, 1, 0);
        step(1, 0, 2, 1, 1, 60, 0, 1, 0, 32'hA5A50002);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 1, 30'(60 + k), k == 3, 0, 1, 0);
        idle();
        // reset during LDR read burst beat 3: pending read return is dropped
        step(0, 0, 0, 1, 0, 8, 0, 0, 1, 32'hA5A50008);
        step(0, 0, 0, 1, 0, 9, 0, 0, 1, 32'hA5A50009);
        step(0, 0, 0, 1, 0, 10, 0, 0, 1, 32'hA5A5000A);
        void'(rd_q.pop_back());
        rst_val = 1'b0;
        repeat (2) step(1, 0, 3, 1, 1, 11, 0, 0, 0, 0);
        rst_val = 1'b1;
        step(1, 1, 34, 1, 1, 11, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1, 11, 1, 0, 1, 0);
        idle();
        // alternating single reads
        step(1, 0, 1, 0, 0, 0, 0, 1, 0, 32'hA5A50001);
        step(0, 0, 0, 1, 0, 2, 1, 0, 1, 32'hA5A50002);
        step(1, 0, 3, 0, 0, 0, 0, 1, 0, 32'hA5A50003);
        step(0, 0, 0, 1, 0, 4, 1, 0, 1, 32'hA5A50004);
        step(1, 0, 5, 0, 0, 0, 0, 1, 0, 32'hA5A50005);
        step(0, 0, 0, 1, 0, 6, 1, 0, 1, 32'hA5A50006);
        idle();
        idle();
        @(negedge clk);
        #1;
        chk("exp_q_drained", exp_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
